// File: rtl/montgomery_exit_reduce.sv
// Montgomery exit stage: R_out = T_in * 2^(-W) mod M_in via bit-serial radix-2 reduction.
// One LOOP iteration per cycle for W cycles, then one conditional subtraction (FIX),
// then a one-cycle FIN state that pulses done.
module montgomery_exit_reduce #(
  parameter int unsigned W = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] M_in,
  input  logic [W-1:0] T_in,
  output logic [W-1:0] R_out,
  output logic         done,
  output logic         err,
  output logic         busy
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoop,
    StFix,
    StFin
  } state_e;

  state_e          state_q, state_d;
  logic [W:0]      a_q, a_d;      // accumulator, one spare bit so A + M never overflows
  logic [W-1:0]    m_q, m_d;      // modulus copy taken at acceptance
  logic [CntW-1:0] cnt_q, cnt_d;  // LOOP iteration counter
  logic [W-1:0]    r_q, r_d;
  logic            err_q, err_d;

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept, halve-with-correction loop, final subtract, result load.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          m_d   = M_in;
          a_d   = {1'b0, T_in};
          cnt_d = '0;
          err_d = 1'b0;
          if (!M_in[0]) begin
            // Even modulus has no inverse of 2: report error, result forced to zero.
            err_d   = 1'b1;
            r_d     = '0;
            state_d = StFin;
          end else begin
            state_d = StLoop;
          end
        end
      end

      StLoop: begin
        // Adding the odd modulus makes A even, so the shift is an exact division by 2 mod M.
        if (a_q[0]) begin
          a_d = (a_q + {1'b0, m_q}) >> 1;
        end else begin
          a_d = a_q >> 1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StFix;
        end
      end

      StFix: begin
        // A < 2M here, so one subtraction brings it into [0, M).
        if (a_q >= {1'b0, m_q}) begin
          a_d = {1'b0, a_q[W-1:0] - m_q};
          r_d = a_q[W-1:0] - m_q;
        end else begin
          r_d = a_q[W-1:0];
        end
        state_d = StFin;
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Status outputs decoded from the state register; result and error are registered.
  always_comb begin
    done  = (state_q == StFin);
    busy  = (state_q == StLoop) || (state_q == StFix);
    R_out = r_q;
    err   = err_q;
  end

endmodule

// File: tb/tb_montgomery_exit_reduce.sv
// Bench for montgomery_exit_reduce: a W=8 instance for directed and random checks,
// and a W=1024 instance for full-width checks against an independent modular model.
module tb_montgomery_exit_reduce;

  localparam int unsigned WS = 8;
  localparam int unsigned WB = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst8, start8, done8, err8, busy8;
  logic [WS-1:0] m8, t8, r8;
  logic          rst1k, start1k, done1k, err1k, busy1k;
  logic [WB-1:0] m1k, t1k, r1k;

  int checks = 0;
  int failures = 0;

  montgomery_exit_reduce #(.W(WS)) dut8 (
    .clk   (clk),
    .reset (rst8),
    .start (start8),
    .M_in  (m8),
    .T_in  (t8),
    .R_out (r8),
    .done  (done8),
    .err   (err8),
    .busy  (busy8)
  );

  montgomery_exit_reduce #(.W(WB)) dut1k (
    .clk   (clk),
    .reset (rst1k),
    .start (start1k),
    .M_in  (m1k),
    .T_in  (t1k),
    .R_out (r1k),
    .done  (done1k),
    .err   (err1k),
    .busy  (busy1k)
  );

  // Reference for W=8: the unique r in [0, M) with r * 256 == T (mod M).
  function automatic int ref8(input int m, input int t);
    for (int r = 0; r < m; r++) begin
      if (((r * 256) % m) == (t % m)) return r;
    end
    return -1;
  endfunction

  // r * 2^1024 mod m by repeated modular doubling; r must already be below m.
  function automatic logic [WB-1:0] mul_r(input logic [WB-1:0] r, input logic [WB-1:0] m);
    logic [WB:0] x;
    x = {1'b0, r};
    for (int i = 0; i < WB; i++) begin
      x = x << 1;
      if (x >= {1'b0, m}) x = x - {1'b0, m};
    end
    return x[WB-1:0];
  endfunction

  // Start one W=8 operation; returns result, error, latency (-1 on timeout), busy-cycle count.
  task automatic run8(input int m, input int t, output int r, output bit e, output int lat,
                      output int bcnt);
    @(negedge clk);
    m8 = WS'(m);
    t8 = WS'(t);
    start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    lat = -1;
    bcnt = 0;
    r = -1;
    e = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy8) bcnt++;
      if (done8) begin
        lat = c;
        r = int'(r8);
        e = err8;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic run1k(input logic [WB-1:0] m, input logic [WB-1:0] t,
                       output logic [WB-1:0] r, output int lat);
    @(negedge clk);
    m1k = m;
    t1k = t;
    start1k = 1'b1;
    @(posedge clk);
    #1 start1k = 1'b0;
    lat = -1;
    r = '0;
    for (int c = 1; c <= 1100; c++) begin
      @(negedge clk);
      if (done1k) begin
        lat = c;
        r = r1k;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst8 = 1'b1;
    rst1k = 1'b1;
    start8 = 1'b0;
    start1k = 1'b0;
    m8 = '0;
    t8 = '0;
    m1k = '0;
    t1k = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (r8 !== 8'd0) begin failures++; $display("FAIL reset_r8 got %0d want 0", r8); end
    checks++;
    if ({done8, err8, busy8} !== 3'b000) begin
      failures++; $display("FAIL reset_flags8 got %b want 000", {done8, err8, busy8});
    end
    checks++;
    if (r1k !== '0) begin failures++; $display("FAIL reset_r1k got nonzero want 0"); end
    checks++;
    if ({done1k, err1k, busy1k} !== 3'b000) begin
      failures++; $display("FAIL reset_flags1k got %b want 000", {done1k, err1k, busy1k});
    end
    @(posedge clk);
    #1;
    rst8 = 1'b0;
    rst1k = 1'b0;
  endtask

  task automatic test_vectors();
    int vm[4] = '{13, 13, 13, 13};
    int vt[4] = '{1, 9, 12, 0};
    int vr[4] = '{3, 1, 10, 0};
    int r, lat, bc;
    bit e;
    for (int i = 0; i < 4; i++) begin
      run8(vm[i], vt[i], r, e, lat, bc);
      checks++;
      if (r !== vr[i]) begin
        failures++; $display("FAIL vec%0d_result got %0d want %0d", i, r, vr[i]);
      end
      checks++;
      if (lat !== WS + 2) begin
        failures++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, WS + 2);
      end
      checks++;
      if (e !== 1'b0) begin failures++; $display("FAIL vec%0d_err got %b want 0", i, e); end
      checks++;
      if (bc !== WS + 1) begin
        failures++; $display("FAIL vec%0d_busy_cycles got %0d want %0d", i, bc, WS + 1);
      end
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0) begin failures++; $display("FAIL done_single_pulse got 1 want 0"); end
  endtask

  task automatic test_even();
    int r, lat, bc;
    bit e;
    run8(12, 5, r, e, lat, bc);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL even_latency got %0d want 1", lat); end
    checks++;
    if (e !== 1'b1) begin failures++; $display("FAIL even_err got %b want 1", e); end
    checks++;
    if (r !== 0) begin failures++; $display("FAIL even_result got %0d want 0", r); end
    repeat (3) @(negedge clk);
    checks++;
    if (err8 !== 1'b1) begin failures++; $display("FAIL even_err_held got %b want 1", err8); end
    run8(13, 1, r, e, lat, bc);
    checks++;
    if (e !== 1'b0) begin failures++; $display("FAIL after_even_err got %b want 0", e); end
    checks++;
    if (r !== 3) begin failures++; $display("FAIL after_even_result got %0d want 3", r); end
  endtask

  task automatic test_ignored_start();
    int ndone = 0;
    int dcyc = -1;
    int busy_late = 0;
    @(negedge clk);
    m8 = 8'd13;
    t8 = 8'd1;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 30; c++) begin
      start8 = (c == 3 || c == 10);
      if (c == 2) begin
        m8 = 8'($urandom_range(0, 255));
        t8 = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      if (done8) begin ndone++; dcyc = c; end
      if (c > 10 && busy8) busy_late++;
      @(posedge clk);
      #1;
    end
    start8 = 1'b0;
    checks++;
    if (ndone !== 1) begin failures++; $display("FAIL ignored_start_done_count got %0d want 1", ndone); end
    checks++;
    if (dcyc !== WS + 2) begin
      failures++; $display("FAIL ignored_start_done_cycle got %0d want %0d", dcyc, WS + 2);
    end
    checks++;
    if (busy_late !== 0) begin failures++; $display("FAIL ignored_start_restart got %0d busy cycles want 0", busy_late); end
    checks++;
    if (r8 !== 8'd3) begin failures++; $display("FAIL ignored_start_result got %0d want 3", r8); end
  endtask

  task automatic test_reset_abort();
    int ndone = 0;
    int r, lat, bc;
    bit e;
    @(negedge clk);
    m8 = 8'd13;
    t8 = 8'd1;
    start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst8 = 1'b1;
    #1;
    checks++;
    if (r8 !== 8'd0) begin failures++; $display("FAIL abort_result got %0d want 0", r8); end
    checks++;
    if ({done8, err8, busy8} !== 3'b000) begin
      failures++; $display("FAIL abort_flags got %b want 000", {done8, err8, busy8});
    end
    @(posedge clk);
    #1 rst8 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    checks++;
    if (ndone !== 0) begin failures++; $display("FAIL abort_no_done got %0d pulses want 0", ndone); end
    run8(13, 1, r, e, lat, bc);
    checks++;
    if (r !== 3) begin failures++; $display("FAIL abort_rerun_result got %0d want 3", r); end
    checks++;
    if (lat !== WS + 2) begin failures++; $display("FAIL abort_rerun_latency got %0d want %0d", lat, WS + 2); end
  endtask

  task automatic test_back_to_back();
    int r, lat, bc;
    bit e;
    time t0, t1;
    run8(13, 12, r, e, lat, bc);
    t0 = $time;
    checks++;
    if (r !== 10) begin failures++; $display("FAIL b2b_first got %0d want 10", r); end
    run8(11, 5, r, e, lat, bc);
    t1 = $time;
    checks++;
    if (r !== ref8(11, 5)) begin failures++; $display("FAIL b2b_second got %0d want %0d", r, ref8(11, 5)); end
    checks++;
    if ((t1 - t0) !== time'((WS + 3) * 10)) begin
      failures++; $display("FAIL b2b_spacing got %0t want %0d", t1 - t0, (WS + 3) * 10);
    end
  endtask

  task automatic test_random();
    int m, t, r, lat, bc, want;
    bit e;
    for (int i = 0; i < 25; i++) begin
      m = 2 * $urandom_range(1, 127) + 1;
      t = $urandom_range(0, (2 * m - 1 > 255) ? 255 : 2 * m - 1);
      want = ref8(m, t);
      run8(m, t, r, e, lat, bc);
      checks++;
      if (r !== want || e !== 1'b0 || lat !== WS + 2) begin
        failures++;
        $display("FAIL random M=%0d T=%0d got r=%0d err=%b lat=%0d want r=%0d err=0 lat=%0d",
                 m, t, r, e, lat, want, WS + 2);
      end
    end
  endtask

  task automatic test_wide();
    logic [WB-1:0] m, rr, r, t;
    int lat;
    m = {32{32'hD1B5_4A37}};
    rr = mul_r(1, m);
    run1k(m, rr, r, lat);
    checks++;
    if (r !== 1) begin failures++; $display("FAIL wide_rmodm got %h want 1", r[63:0]); end
    checks++;
    if (lat !== WB + 2) begin failures++; $display("FAIL wide_latency got %0d want %0d", lat, WB + 2); end
    run1k(m, 1, r, lat);
    checks++;
    if (r >= m || mul_r(r, m) !== 1) begin
      failures++; $display("FAIL wide_inverse got low64 %h not a valid 2^-1024 mod M", r[63:0]);
    end
    for (int k = 0; k < 32; k++) t[k*32 +: 32] = $urandom;
    t = t % m;
    run1k(m, t, r, lat);
    checks++;
    if (r >= m || mul_r(r, m) !== t) begin
      failures++; $display("FAIL wide_random got low64 %h want r*2^1024 == T low64 %h", r[63:0], t[63:0]);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_even();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
